// File: rtl/rcg_ctrl_div_req.sv
// -----------------------------------------------------------------------------
// rcg_ctrl_div_req
//
// Purpose
//    Applies new division ratios to a bank of clock-divider controllers using a
//    4-phase request/acknowledge handshake. A ratio written by software is held
//    in a pending buffer. It is copied onto div_ratio only when no divider is
//    still acknowledging a previous request. After one settle cycle the block
//    raises divider_go and waits for every divider to acknowledge. It then drops
//    divider_go and waits for every acknowledge to fall. If either phase takes
//    too long, the sticky upd_timeout flag is raised.
//
// Parameters
//    DIV_NUM    number of divider controllers driven
//    DIV_WIDTH  ratio width per divider
//    RATIO_RST  ratio loaded into every slice (and the pending buffer) at reset
//    TO_WIDTH   timeout counter width; a phase gives up after 2^TO_WIDTH-1 cycles
//
// Ports
//    clk_in              in   1                   divider domain clock, rising edge
//    hgrst_n             in   1                   asynchronous active-low reset
//    cfg_wr              in   1                   one-cycle request to apply cfg_ratio
//    cfg_ratio           in   DIV_NUM*DIV_WIDTH   new ratios, slice i at [i*DIV_WIDTH +: DIV_WIDTH]
//    status_clr          in   1                   clears upd_timeout
//    divider_go_ack_vec  in   DIV_NUM             per-divider acknowledge (already in clk_in domain)
//    div_ratio           out  DIV_NUM*DIV_WIDTH   registered ratios to the dividers
//    divider_go          out  1                   registered update request, common to all dividers
//    upd_busy            out  1                   update in progress or pending
//    upd_done            out  1                   one-cycle pulse when a handshake completes
//    upd_timeout         out  1                   sticky handshake-timeout flag
// -----------------------------------------------------------------------------
module rcg_ctrl_div_req #(
   parameter int DIV_NUM   = 1,
   parameter int DIV_WIDTH = 16,
   parameter int RATIO_RST = 1,
   parameter int TO_WIDTH  = 10
) (
   input  logic                           clk_in,
   input  logic                           hgrst_n,
   input  logic                           cfg_wr,
   input  logic [DIV_NUM*DIV_WIDTH-1:0]   cfg_ratio,
   input  logic                           status_clr,
   input  logic [DIV_NUM-1:0]             divider_go_ack_vec,
   output logic [DIV_NUM*DIV_WIDTH-1:0]   div_ratio,
   output logic                           divider_go,
   output logic                           upd_busy,
   output logic                           upd_done,
   output logic                           upd_timeout
);

   // A phase lasts at most TO_MAX cycles. The counter starts at 0 in the
   // first cycle of a phase, so the give-up decision is taken when it holds
   // TO_MAX-1. That decision is the TO_MAX-th cycle of the phase.
   localparam int                    TO_MAX      = (1 << TO_WIDTH) - 1;
   localparam logic [TO_WIDTH-1:0]   TO_LAST     = TO_WIDTH'(TO_MAX - 1);
   localparam logic [DIV_WIDTH-1:0]  RATIO_RST_W = DIV_WIDTH'(RATIO_RST);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_REQ,
      ST_RELEASE,
      ST_DONE
   } state_t;

   state_t                 state_reg;
   logic [TO_WIDTH-1:0]    cnt_reg;
   logic                   pend_reg;
   logic                   go_reg;
   logic                   done_reg;
   logic                   timeout_reg;
   logic                   to_hit_reg;     // current handshake already timed out in REQ
   logic [1:0]             rst_sync_reg;
   logic                   rst_n;
   logic                   ack_all;
   logic                   ack_any;
   logic                   load_en;

   // --------------------------------------------------------------------------
   // Reset conditioning. Assertion reaches every flop at once, so divider_go
   // drops immediately even in the middle of a handshake. Release is re-timed
   // to clk_in through two flops. The first state change therefore cannot
   // happen before the second rising edge after hgrst_n deasserts.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge hgrst_n) begin
      if (!hgrst_n) begin
         rst_sync_reg <= 2'b00;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      end
   end

   assign rst_n   = rst_sync_reg[1];

   assign ack_all = &divider_go_ack_vec;
   assign ack_any = |divider_go_ack_vec;
   assign load_en = (state_reg == ST_LOAD);

   // --------------------------------------------------------------------------
   // Per-divider data path: pending buffer (last cfg_wr wins) and the ratio
   // register presented to the divider. div_ratio changes only in LOAD. That
   // keeps it stable through SETUP, REQ and RELEASE.
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DIV_NUM; gi++) begin : g_slice
         logic [DIV_WIDTH-1:0] pend_buf_reg;
         logic [DIV_WIDTH-1:0] ratio_reg;

         always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
               pend_buf_reg <= RATIO_RST_W;
               ratio_reg    <= RATIO_RST_W;
            end else begin
               if (cfg_wr) begin
                  pend_buf_reg <= cfg_ratio[gi*DIV_WIDTH +: DIV_WIDTH];
               end
               // A cfg_wr in the LOAD cycle itself is not lost. The buffer
               // takes the new value here, LOAD copies the older one, and
               // pend stays set so a second update follows.
               if (load_en) begin
                  ratio_reg <= pend_buf_reg;
               end
            end
         end

         assign div_ratio[gi*DIV_WIDTH +: DIV_WIDTH] = ratio_reg;
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Handshake FSM with registered outputs.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         pend_reg    <= 1'b0;
         go_reg      <= 1'b0;
         done_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         to_hit_reg  <= 1'b0;
      end else begin
         if (cfg_wr) begin
            pend_reg <= 1'b1;
         end

         // The clear comes first. Any timeout set below in the same cycle
         // overrides it.
         if (status_clr) begin
            timeout_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               go_reg   <= 1'b0;
               done_reg <= 1'b0;
               cnt_reg  <= '0;
               // Do not start while any divider still acknowledges an
               // earlier request, e.g. after a timeout or reset.
               if ((pend_reg || cfg_wr) && !ack_any) begin
                  state_reg <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (!cfg_wr) begin
                  pend_reg <= 1'b0;
               end
               to_hit_reg <= 1'b0;
               state_reg  <= ST_SETUP;
            end

            ST_SETUP: begin
               go_reg    <= 1'b1;
               cnt_reg   <= '0;
               state_reg <= ST_REQ;
            end

            ST_REQ: begin
               // Only a cycle with every ack high counts. Partial acks, or an
               // ack that rose and fell again, keep the request waiting.
               if (ack_all) begin
                  go_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= ST_RELEASE;
               end else if (cnt_reg == TO_LAST) begin
                  go_reg      <= 1'b0;
                  cnt_reg     <= '0;
                  timeout_reg <= 1'b1;
                  to_hit_reg  <= 1'b1;
                  state_reg   <= ST_RELEASE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            ST_RELEASE: begin
               if (!ack_any) begin
                  // A handshake that timed out in REQ never completed. It
                  // still drains through DONE, but with no upd_done pulse.
                  done_reg  <= !to_hit_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_DONE;
               end else if (cnt_reg == TO_LAST) begin
                  cnt_reg     <= '0;
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            ST_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               go_reg    <= 1'b0;
               done_reg  <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign divider_go  = go_reg;
   assign upd_done    = done_reg;
   assign upd_timeout = timeout_reg;
   assign upd_busy    = (state_reg != ST_IDLE) || pend_reg;

endmodule

// File: tb/tb_rcg_ctrl_div_req.sv
// -----------------------------------------------------------------------------
// tb_rcg_ctrl_div_req
//
// Testbench for rcg_ctrl_div_req with DIV_NUM=2, DIV_WIDTH=16, RATIO_RST=3
// and TO_WIDTH=4. Randomised update scenarios are planned ahead of time as a
// per-cycle timeline built from the handshake rules:
//    - the ratio appears 2 cycles after the write;
//    - go rises 3 cycles after the write and falls 1 cycle after all acks;
//    - upd_done follows all acks low by 1 cycle;
//    - each phase is bounded at 15 cycles.
// The acknowledge stimulus follows the same plan. The DUT is then run
// against the plan cycle by cycle.
// -----------------------------------------------------------------------------
module tb_rcg_ctrl_div_req;

   localparam int          DIV_NUM   = 2;
   localparam int          DIV_WIDTH = 16;
   localparam int          RATIO_RST = 3;
   localparam int          TO_WIDTH  = 4;
   localparam int          MAXC      = 1024;
   localparam logic [31:0] RR        = {16'd3, 16'd3};

   logic          clk_in;
   logic          hgrst_n;
   logic          cfg_wr;
   logic [31:0]   cfg_ratio;
   logic          status_clr;
   logic [1:0]    divider_go_ack_vec;
   logic [31:0]   div_ratio;
   logic          divider_go;
   logic          upd_busy;
   logic          upd_done;
   logic          upd_timeout;

   int            check_cnt;
   int            err_cnt;

   // Planned stimulus and expected outputs, indexed by cycle.
   bit            cfg_wr_s    [MAXC];
   logic [31:0]   cfg_ratio_s [MAXC];
   bit   [1:0]    ack_s       [MAXC];
   bit            clr_s       [MAXC];
   logic [31:0]   exp_ratio   [MAXC];
   bit            exp_go      [MAXC];
   bit            exp_done    [MAXC];
   bit            exp_busy    [MAXC];
   bit            exp_to      [MAXC];

   rcg_ctrl_div_req #(
      .DIV_NUM   (DIV_NUM),
      .DIV_WIDTH (DIV_WIDTH),
      .RATIO_RST (RATIO_RST),
      .TO_WIDTH  (TO_WIDTH)
   ) dut (
      .clk_in             (clk_in),
      .hgrst_n            (hgrst_n),
      .cfg_wr             (cfg_wr),
      .cfg_ratio          (cfg_ratio),
      .status_clr         (status_clr),
      .divider_go_ack_vec (divider_go_ack_vec),
      .div_ratio          (div_ratio),
      .divider_go         (divider_go),
      .upd_busy           (upd_busy),
      .upd_done           (upd_done),
      .upd_timeout        (upd_timeout)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      check_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // ---------------- planning helpers ----------------
   task automatic fill_ratio(input int from, input logic [31:0] v);
      for (int c = from; c < MAXC; c++) exp_ratio[c] = v;
   endtask

   task automatic fill_to(input int from, input bit v);
      for (int c = from; c < MAXC; c++) exp_to[c] = v;
   endtask

   task automatic set_go(input int a, input int b);
      for (int c = a; c <= b; c++) exp_go[c] = 1'b1;
   endtask

   task automatic set_busy(input int a, input int b);
      for (int c = a; c <= b; c++) exp_busy[c] = 1'b1;
   endtask

   task automatic set_ack(input int i, input int a, input int b);
      for (int c = a; c <= b; c++) ack_s[c][i] = 1'b1;
   endtask

   // Complete handshake for an update that starts in IDLE at cycle n. The
   // start comes either from a cfg_wr at n (wr=1) or from a pending write
   // with acks already low (wr=0). Returns the all-acks-low cycle k and the
   // all-acks-high cycle m.
   task automatic plan_normal(input int n, input logic [31:0] r, input bit wr,
                              output int k, output int m);
      int g, d0, d1, dm, l, e0, e1, em;
      g  = n + 3;
      d0 = $urandom_range(1, 5);
      d1 = $urandom_range(1, 5);
      dm = (d0 > d1) ? d0 : d1;
      m  = g + dm;
      l  = m + 1;
      e0 = $urandom_range(0, 4);
      e1 = $urandom_range(0, 4);
      em = (e0 > e1) ? e0 : e1;
      k  = l + em;
      if (wr) begin
         cfg_wr_s[n]    = 1'b1;
         cfg_ratio_s[n] = r;
      end
      fill_ratio(n + 2, r);
      set_go(g, m);
      exp_done[k + 1] = 1'b1;
      set_busy(wr ? n + 1 : n, k + 1);
      set_ack(0, g + d0, l + e0 - 1);
      set_ack(1, g + d1, l + e1 - 1);
      $display("plan update: start %0d ratio %h go %0d..%0d done %0d", n, r, g, m, k + 1);
   endtask

   // ---------------- plan the whole run ----------------
   int t, n, k, m, k2, m2, g, l, d0, d1, e0, e1, p, f, a, b;
   logic [31:0] r, r5, r7;

   initial begin
      for (int c = 0; c < MAXC; c++) begin
         cfg_wr_s[c] = 0; cfg_ratio_s[c] = '0; ack_s[c] = '0; clr_s[c] = 0;
         exp_ratio[c] = RR; exp_go[c] = 0; exp_done[c] = 0; exp_busy[c] = 0; exp_to[c] = 0;
      end
      t = 3;

      // Plain updates, every second one with two extra writes during REQ.
      for (int it = 0; it < 6; it++) begin
         n = t + $urandom_range(0, 3);
         r = $urandom;
         plan_normal(n, r, 1'b1, k, m);
         if (it % 2 == 1) begin
            r5 = $urandom;
            r7 = $urandom;
            a  = n + 3;
            b  = n + 3 + $urandom_range(1, m - (n + 3));
            cfg_wr_s[a] = 1'b1; cfg_ratio_s[a] = r5;
            cfg_wr_s[b] = 1'b1; cfg_ratio_s[b] = r7;
            $display("plan writes during REQ: %h at %0d, %h at %0d", r5, a, r7, b);
            plan_normal(k + 2, r7, 1'b0, k2, m2);
            k = k2;
         end
         t = k + 2;
      end

      // Divider 1 never acknowledges: REQ gives up after 15 cycles.
      n  = t + 1;
      r  = $urandom;
      g  = n + 3;
      d0 = $urandom_range(1, 5);
      l  = g + 15;
      e0 = $urandom_range(0, 4);
      k  = l + e0;
      cfg_wr_s[n] = 1'b1; cfg_ratio_s[n] = r;
      fill_ratio(n + 2, r);
      set_go(g, g + 14);
      set_busy(n + 1, k + 1);
      fill_to(l, 1'b1);
      set_ack(0, g + d0, l + e0 - 1);
      clr_s[k + 3] = 1'b1;
      fill_to(k + 4, 1'b0);
      $display("plan REQ timeout: start %0d ratio %h go %0d..%0d clear %0d", n, r, g, g + 14, k + 3);
      t = k + 5;

      // Divider 0 holds its ack: RELEASE gives up, with status_clr in the
      // same cycle. A new write then waits in IDLE until the ack falls.
      n  = t + 1;
      r  = $urandom;
      g  = n + 3;
      d0 = $urandom_range(1, 4);
      d1 = $urandom_range(1, 4);
      m  = g + ((d0 > d1) ? d0 : d1);
      l  = m + 1;
      e1 = $urandom_range(0, 4);
      cfg_wr_s[n] = 1'b1; cfg_ratio_s[n] = r;
      fill_ratio(n + 2, r);
      set_go(g, m);
      set_busy(n + 1, l + 14);
      clr_s[l + 14] = 1'b1;
      fill_to(l + 15, 1'b1);
      p = l + 17;
      f = p + 3;
      set_ack(0, g + d0, f - 1);
      set_ack(1, g + d1, l + e1 - 1);
      r = $urandom;
      cfg_wr_s[p] = 1'b1; cfg_ratio_s[p] = r;
      set_busy(p + 1, f - 1);
      $display("plan RELEASE timeout: start %0d expiry %0d, write %0d held until %0d", n, l + 14, p, f);
      plan_normal(f, r, 1'b0, k2, m2);
      clr_s[k2 + 3] = 1'b1;
      fill_to(k2 + 4, 1'b0);
      t = k2 + 5;

      if (t + 8 > MAXC) begin
         $display("FAIL plan: schedule length %0d exceeds %0d", t, MAXC);
         $fatal(1, "schedule too long");
      end
   end

   // ---------------- run ----------------
   logic [31:0] rd;

   initial begin
      check_cnt  = 0;
      err_cnt    = 0;
      hgrst_n    = 1'b0;
      cfg_wr     = 1'b0;
      cfg_ratio  = '0;
      status_clr = 1'b0;
      divider_go_ack_vec = '0;
      repeat (3) @(posedge clk_in);
      #1 hgrst_n = 1'b1;
      repeat (3) @(posedge clk_in);

      for (int c = 0; c < t + 4; c++) begin
         @(posedge clk_in);
         #1;
         cfg_wr             = cfg_wr_s[c];
         cfg_ratio          = cfg_ratio_s[c];
         status_clr         = clr_s[c];
         divider_go_ack_vec = ack_s[c];
         @(negedge clk_in);
         check_val($sformatf("ratio@%0d", c),   div_ratio,   exp_ratio[c]);
         check_val($sformatf("go@%0d", c),      {31'd0, divider_go},  {31'd0, exp_go[c]});
         check_val($sformatf("done@%0d", c),    {31'd0, upd_done},    {31'd0, exp_done[c]});
         check_val($sformatf("busy@%0d", c),    {31'd0, upd_busy},    {31'd0, exp_busy[c]});
         check_val($sformatf("timeout@%0d", c), {31'd0, upd_timeout}, {31'd0, exp_to[c]});
      end

      // Reset asserted while the request is out.
      rd = $urandom;
      @(posedge clk_in);
      #1 cfg_wr = 1'b1; cfg_ratio = rd; status_clr = 1'b0; divider_go_ack_vec = '0;
      @(posedge clk_in);
      #1 cfg_wr = 1'b0;
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      check_val("rst_pre_go",    {31'd0, divider_go}, 32'd1);
      check_val("rst_pre_ratio", div_ratio, rd);
      check_val("rst_pre_busy",  {31'd0, upd_busy}, 32'd1);
      #2 hgrst_n = 1'b0;
      #1;
      check_val("rst_go",      {31'd0, divider_go},  32'd0);
      check_val("rst_ratio",   div_ratio, RR);
      check_val("rst_busy",    {31'd0, upd_busy},    32'd0);
      check_val("rst_done",    {31'd0, upd_done},    32'd0);
      check_val("rst_timeout", {31'd0, upd_timeout}, 32'd0);
      repeat (2) @(posedge clk_in);
      #1 hgrst_n = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      check_val("post_rst_go",    {31'd0, divider_go}, 32'd0);
      check_val("post_rst_busy",  {31'd0, upd_busy},   32'd0);
      check_val("post_rst_ratio", div_ratio, RR);
      $display("reset during REQ: ratio %h dropped back to %h", rd, RR);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/rcg_ctrl_div_req.md
RCG_CTRL_DIV_REQ -- requirements
Module: rcg_ctrl_div_req

Interface
REQ-001 Parameter DIV_NUM, default 1, number of divider controllers driven.
REQ-002 Parameter DIV_WIDTH, default 16, ratio width per divider.
REQ-003 Parameter RATIO_RST, default 1, reset ratio loaded into every divider slice.
REQ-004 Parameter TO_WIDTH, default 10, timeout counter width; limit TO_MAX = 2^TO_WIDTH-1 cycles.
REQ-005 Reset hgrst_n, asynchronous, active-low; clock clk_in.
REQ-006 clk_in  input  1  divider domain clock; all logic on its rising edge.
REQ-007 hgrst_n  input  1  asynchronous active-low reset.
REQ-008 cfg_wr  input  1  one-cycle request to apply cfg_ratio.
REQ-009 cfg_ratio  input  DIV_NUM*DIV_WIDTH  new ratios; slice i = bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-010 status_clr  input  1  clears upd_timeout.
REQ-011 divider_go_ack_vec  input  DIV_NUM  per-divider ack, clk_in domain, no sync.
REQ-012 div_ratio  output  DIV_NUM*DIV_WIDTH  registered ratios to dividers.
REQ-013 divider_go  output  1  registered update request, common to all dividers.
REQ-014 upd_busy  output  1  update in progress or pending.
REQ-015 upd_done  output  1  one-cycle pulse at handshake completion.
REQ-016 upd_timeout  output  1  sticky handshake-timeout flag.

Function
REQ-017 FSM states IDLE, LOAD, SETUP, REQ, RELEASE, DONE; 4-phase handshake: go high, all acks high, go low, all acks low.
REQ-018 cfg_wr in any cycle captures cfg_ratio into pending buffer and sets pend; later cfg_wr overwrites (last wins).
REQ-019 IDLE -> LOAD when (pend or cfg_wr) and divider_go_ack_vec all zero; otherwise stay IDLE with pend held.
REQ-020 LOAD: div_ratio <= pending buffer, pend cleared unless cfg_wr same cycle; -> SETUP.
REQ-021 SETUP: one cycle, div_ratio stable; -> REQ.
REQ-022 Latency: cfg_wr at cycle N in IDLE with acks low -> new div_ratio visible N+2, divider_go high N+3.
REQ-023 div_ratio changes only on LOAD; constant whenever divider_go=1 and through RELEASE.
REQ-024 REQ: divider_go=1; timeout counter increments each cycle from 0.
REQ-025 REQ: &divider_go_ack_vec at cycle M -> RELEASE, divider_go=0 from M+1.
REQ-026 REQ: counter reaching TO_MAX without all acks -> upd_timeout set, -> RELEASE; counter restarts at 0.
REQ-027 RELEASE: divider_go=0; |divider_go_ack_vec=0 at cycle K -> DONE, upd_done=1 at K+1 only.
REQ-028 RELEASE: counter reaching TO_MAX with any ack high -> upd_timeout set, -> IDLE, no upd_done.
REQ-029 DONE: one cycle -> IDLE; pend set -> next update begins per REQ-019.
REQ-030 upd_busy = (state != IDLE) | pend, registered/combinational same-cycle as state.
REQ-031 status_clr clears upd_timeout next cycle; simultaneous set and clear -> set wins.
REQ-032 Partial acks (subset high) in REQ do not advance FSM.
REQ-033 Ack dropping before divider_go falls is ignored; only all-high sampled in REQ counts.

Reset
REQ-034 hgrst_n low asynchronously forces: state IDLE, every div_ratio slice = RATIO_RST, divider_go=0, upd_done=0, upd_timeout=0, pend=0, counter=0, pending buffer=RATIO_RST.
REQ-035 Reset mid-handshake drops divider_go immediately; no upd_done issued; after release FSM waits in IDLE for acks low.
REQ-036 Reset release synchronous to clk_in; first transition no earlier than second rising edge after deassert.

Verification
REQ-037 DIV_NUM=2, cfg_wr at N with ratio {16'h0004,16'h0008}, acks follow go after 3 cycles -> div_ratio new at N+2, go high N+3, go low one cycle after both acks, upd_done single pulse, upd_timeout=0.
REQ-038 One ack stuck low, TO_WIDTH=4 -> go high 15 cycles, upd_timeout=1, go low, no upd_done; status_clr -> upd_timeout=0.
REQ-039 Two cfg_wr during REQ (ratios 5 then 7) -> after first upd_done, second update applies 7 only; 5 never appears on div_ratio; upd_busy high throughout.
REQ-040 cfg_wr while acks still high from prior handshake -> FSM stays IDLE, upd_busy=1, LOAD only after acks fall.
REQ-041 hgrst_n asserted in REQ -> divider_go=0 same cycle asynchronously, div_ratio=RATIO_RST, upd_busy=0.
REQ-042 status_clr coincident with timeout expiry -> upd_timeout=1.
